// File: rtl/dm_arbiter_if.sv
// Bundle of the two requester ports and the DataMem port of dm_arbiter.
// The slave modport is the arbiter side; the master modport is the
// environment side (requesters plus the memory's read data).
interface dm_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 10
);

  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic          busy;

  logic          dmWrite;
  logic [DW-1:0] dmWrDat;
  logic [AW-1:0] dmWrDat_addr;
  logic [AW-1:0] dmReDat_addr;
  logic [DW-1:0] dmReDat;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  dmReDat,
    output ack0, rdata0, ack1, rdata1, busy,
    output dmWrite, dmWrDat, dmWrDat_addr, dmReDat_addr
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output dmReDat,
    input  ack0, rdata0, ack1, rdata1, busy,
    input  dmWrite, dmWrDat, dmWrDat_addr, dmReDat_addr
  );

endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter and sequencer in front of the single-write-port DataMem.
// Each transaction runs IDLE -> SETUP -> ACCESS -> DONE; all DataMem-side
// outputs come straight from flops so the write enable cannot glitch.
// Optional macro DM_ARB_FIXED_PRIO_EN: port 0 always wins simultaneous
// requests (default build: round-robin on lastGnt).
module dm_arbiter #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input logic         clk,
  input logic         rst_n,
  dm_arbiter_if.slave bus
);

  localparam logic [DW-1:0] DATA_ZERO = '0;
  localparam logic [AW-1:0] ADDR_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic last_gnt;
  logic winner;
  logic op_write;
  logic grant;
  logic grant_port;

  // Pick the winning port from the live requests seen in IDLE
  always_comb begin
    grant      = bus.req0 | bus.req1;
    grant_port = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
      grant_port = 1'b0;
`else
      grant_port = ~last_gnt;
`endif
    end else if (bus.req1) begin
      grant_port = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: only IDLE waits, every other phase lasts one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the granted transaction, sequence the write strobe, capture reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt         <= 1'b1;
      winner           <= 1'b0;
      op_write         <= 1'b0;
      bus.dmWrite      <= 1'b0;
      bus.dmWrDat      <= DATA_ZERO;
      bus.dmWrDat_addr <= ADDR_ZERO;
      bus.dmReDat_addr <= ADDR_ZERO;
      bus.rdata0       <= DATA_ZERO;
      bus.rdata1       <= DATA_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            winner           <= grant_port;
            last_gnt         <= grant_port;
            op_write         <= grant_port ? bus.we1 : bus.we0;
            bus.dmWrDat      <= grant_port ? bus.wdata1 : bus.wdata0;
            bus.dmWrDat_addr <= grant_port ? bus.addr1 : bus.addr0;
            bus.dmReDat_addr <= grant_port ? bus.addr1 : bus.addr0;
          end
        end
        SETUP: begin
          bus.dmWrite <= op_write;
        end
        ACCESS: begin
          bus.dmWrite <= 1'b0;
          if (!op_write) begin
            if (winner) bus.rdata1 <= bus.dmReDat;
            else        bus.rdata0 <= bus.dmReDat;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.ack0 = (state == DONE) && !winner;
  assign bus.ack1 = (state == DONE) && winner;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by random
// two-port traffic, checked against a transaction-level model of the
// arbitration rule and the memory contents.
module tb_dm_arbiter;

  localparam int DW = 16;
  localparam int AW = 10;
`ifdef DM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic clearMem;

  dm_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  dm_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // DataMem stand-in: write completes at the edge ending the strobe cycle
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (clearMem) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (bus.dmWrite) begin
      mem[bus.dmWrDat_addr] <= bus.dmWrDat;
    end
  end
  assign bus.dmReDat = mem[bus.dmReDat_addr];

  int checks = 0;
  int errors = 0;
  int refMem [1024];
  int refRd  [2];
  int refLast;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int predictWinner(input bit r0, input bit r1);
    if (r0 && r1) return FIXED ? 0 : (refLast == 0 ? 1 : 0);
    return r1 ? 1 : 0;
  endfunction

  task automatic applyStimulus(input int port, input bit req, input bit we, input int addr, input int data);
    if (port == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = AW'(addr); bus.wdata0 = DW'(data);
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = AW'(addr); bus.wdata1 = DW'(data);
    end
  endtask

  task automatic doReset(input bit wipe, input bit check);
    rst_n    = 1'b0;
    clearMem = wipe;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    if (check) begin
      checkOutput("rst_ack0", bus.ack0, 0);
      checkOutput("rst_ack1", bus.ack1, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_dmWrite", bus.dmWrite, 0);
      checkOutput("rst_rdata0", bus.rdata0, 0);
      checkOutput("rst_rdata1", bus.rdata1, 0);
      checkOutput("rst_dmWrDat", bus.dmWrDat, 0);
      checkOutput("rst_dmWrDat_addr", bus.dmWrDat_addr, 0);
      checkOutput("rst_dmReDat_addr", bus.dmReDat_addr, 0);
    end
    if (wipe) for (int i = 0; i < 1024; i++) refMem[i] = 0;
    clearMem = 1'b0;
    rst_n    = 1'b1;
    refRd[0] = 0;
    refRd[1] = 0;
    refLast  = 1;
  endtask

  // Present up to one transaction per port at once and follow them to their acks
  task automatic runPair(input bit r0, input bit r1, input bit w0, input bit w1,
                         input int a0, input int a1, input int d0, input int d1);
    bit pend [2];
    bit pw [2];
    int pa [2];
    int pd [2];
    int seq [2];
    int nAck = 0;
    int busyCnt = 0;
    int wrCnt = 0;
    int wrA = 0;
    int wrD = 0;
    int p;
    pend[0] = r0; pend[1] = r1;
    pw[0] = w0; pw[1] = w1;
    pa[0] = a0; pa[1] = a1;
    pd[0] = d0; pd[1] = d1;
    seq[0] = predictWinner(r0, r1);
    seq[1] = 1 - seq[0];
    applyStimulus(0, r0, w0, a0, d0);
    applyStimulus(1, r1, w1, a1, d1);
    for (int cyc = 0; cyc < 40 && (pend[0] || pend[1]); cyc++) begin
      @(negedge clk);
      if (bus.busy) busyCnt++;
      if (bus.dmWrite) begin
        wrCnt++;
        wrA = int'(bus.dmWrDat_addr);
        wrD = int'(bus.dmWrDat);
      end
      if (bus.ack0 || bus.ack1) begin
        p = bus.ack1 ? 1 : 0;
        checkOutput("ackExclusive", bus.ack0 & bus.ack1, 0);
        checkOutput("ackPort", p, (nAck < 2) ? seq[nAck] : 32'hFFFF_FFFF);
        checkOutput("latency", busyCnt, 3);
        refLast = p;
        if (pw[p]) begin
          checkOutput("writeStrobeCycles", wrCnt, 1);
          checkOutput("writeAddr", wrA, pa[p]);
          checkOutput("writeData", wrD, pd[p]);
          refMem[pa[p]] = pd[p];
        end else begin
          checkOutput("readNoStrobe", wrCnt, 0);
          refRd[p] = refMem[pa[p]];
        end
        checkOutput("rdata0", bus.rdata0, refRd[0]);
        checkOutput("rdata1", bus.rdata1, refRd[1]);
        pend[p] = 1'b0;
        applyStimulus(p, 0, pw[p], pa[p], pd[p]);
        nAck++;
        busyCnt = 0;
        wrCnt = 0;
      end
    end
    checkOutput("pairTimeout", {pend[0], pend[1]}, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    int lastCyc;
    int cyc;
    int p;
    bit seen;
    bit changed;
    logic [DW-1:0] holdDat;
    logic [AW-1:0] holdWa;
    logic [AW-1:0] holdRa;

    $display("[TB] start, fixed priority = %0d", FIXED);
    doReset(1'b1, 1'b1);

    // Port 0 write then read of the same word
    @(negedge clk);
    runPair(1, 0, 1, 0, 1, 0, 47, 0);
    runPair(1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("t1_readBack", bus.rdata0, 47);

    // Simultaneous requests straight after reset: port 0 first
    doReset(1'b0, 1'b0);
    @(negedge clk);
    runPair(1, 1, 1, 0, 2, 2, 74, 0);
    checkOutput("t2_rdata1", bus.rdata1, 74);

    // Both ports hold read requests for 8 transactions
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 2, 0);
    k = 0;
    lastCyc = 0;
    for (cyc = 0; cyc < 60 && k < 8; cyc++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        p = bus.ack1 ? 1 : 0;
        checkOutput("t3_ackPort", p, predictWinner(1, 1));
        if (k > 0) checkOutput("t3_spacing", cyc - lastCyc, 4);
        refLast = p;
        refRd[p] = refMem[p == 0 ? 1 : 2];
        checkOutput("t3_rdata0", bus.rdata0, refRd[0]);
        checkOutput("t3_rdata1", bus.rdata1, refRd[1]);
        lastCyc = cyc;
        k++;
      end
    end
    checkOutput("t3_count", k, 8);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    // Inputs change after the grant of a write to addr 3
    applyStimulus(0, 1, 1, 3, 11);
    seen = 1'b0;
    for (cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      seen = bus.busy;
    end
    applyStimulus(0, 1, 1, 5, 99);
    seen = 1'b0;
    for (cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.dmWrite) begin
        checkOutput("t4_writeAddr", bus.dmWrDat_addr, 3);
        checkOutput("t4_writeData", bus.dmWrDat, 11);
      end
      seen = bus.ack0;
    end
    checkOutput("t4_ackSeen", seen, 1);
    applyStimulus(0, 0, 0, 0, 0);
    refMem[3] = 11;
    refLast = 0;
    runPair(1, 1, 0, 0, 3, 5, 0, 0);
    checkOutput("t4_addr3", bus.rdata0, 11);
    checkOutput("t4_addr5", bus.rdata1, 0);

    // Reset asserted during the write strobe of a port 1 write
    applyStimulus(1, 1, 1, 7, 16'h1234);
    seen = 1'b0;
    for (cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      seen = bus.dmWrite;
    end
    checkOutput("t5_strobeSeen", seen, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_dmWriteAsync", bus.dmWrite, 0);
    checkOutput("t5_busyAsync", bus.busy, 0);
    checkOutput("t5_ack1Async", bus.ack1, 0);
    doReset(1'b0, 1'b0);
    @(negedge clk);
    runPair(0, 1, 0, 0, 0, 3, 0, 0);
    checkOutput("t5_freshRead", bus.rdata1, 11);

    // Idle hold for 10 cycles
    @(negedge clk);
    holdDat = bus.dmWrDat;
    holdWa  = bus.dmWrDat_addr;
    holdRa  = bus.dmReDat_addr;
    changed = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.dmWrDat !== holdDat || bus.dmWrDat_addr !== holdWa || bus.dmReDat_addr !== holdRa) changed = 1'b1;
      if (bus.dmWrite || bus.busy || bus.ack0 || bus.ack1) seen = 1'b1;
    end
    checkOutput("t6_dmHold", changed, 0);
    checkOutput("t6_quiet", seen, 0);
    checkOutput("t6_holdAddr", holdWa, 3);

    // Random two-port traffic against the model
    for (int r = 0; r < 40; r++) begin
      bit r0;
      bit r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      runPair(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 16'hFFFF)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port-write data memory (`DataMem`: 16-bit words, 10-bit write/read addresses, level-sensitive write enable, combinational read).
- Port 0 is the CPU load/store path. Port 1 is the loader/DMA path.
- Accepts one transaction at a time and drives `DataMem` with glitch-free setup and write phases.
- Returns a one-cycle ack plus registered read data to the winning requester.

Parameters:
- DW, 16, data word width (matches `DataMem` word width)
- AW, 10, address width (matches `DataMem` address width)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  port 0 request, level
- we0  input  1  port 0: 1 = write, 0 = read
- addr0  input  AW  port 0 word address
- wdata0  input  DW  port 0 write data
- ack0  output  1  port 0 transaction complete, 1-cycle pulse
- rdata0  output  DW  port 0 read data, registered
- req1, we1, addr1, wdata1, ack1, rdata1  as port 0, for port 1
- busy  output  1  high whenever state != IDLE
- dmWrite  output  1  to `DataMem` write enable
- dmWrDat  output  DW  to `DataMem` write data
- dmWrDat_addr  output  AW  to `DataMem` write address
- dmReDat_addr  output  AW  to `DataMem` read address
- dmReDat  input  DW  from `DataMem` read data

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; lastGnt = 1, so port 0 wins first.
  - ack0/ack1/dmWrite/busy = 0.
  - rdata0/rdata1/dmWrDat/dmWrDat_addr/dmReDat_addr = 0.
  - dmWrite falls immediately, even mid-write.
- All `DataMem`-side outputs are registered. dmWrite never glitches.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE. One cycle per state except IDLE.
- IDLE:
  - Samples req0/req1 at each rising edge.
  - Any request: select winner, latch its we/addr/wdata, load dmWrDat, dmWrDat_addr, dmReDat_addr, then go to SETUP.
  - No request: stay in IDLE.
- Arbitration:
  - Single request: that port wins.
  - Both requesting: round-robin. Winner = port != lastGnt.
  - lastGnt updates on each grant.
- SETUP: address and data are stable; dmWrite = 0. Next state is ACCESS. If the latched op is a write, dmWrite is set to 1 on entry to ACCESS.
- ACCESS:
  - Write: dmWrite = 1 for exactly this one cycle.
  - Read: dmWrite stays 0.
  - On the exit edge: dmWrite -> 0; for a read, dmReDat is captured into the winner's rdata.
  - The other port's rdata is unchanged. rdata of the winner is unchanged on a write.
  - Next state is DONE.
- DONE: winner's ack = 1 for this cycle only. Next state is IDLE.
- Request sampling:
  - req is not sampled in SETUP, ACCESS or DONE.
  - Changes on we/addr/wdata/req after the grant are ignored; the latched transaction always completes.
- Requester protocol:
  - Hold req until ack is seen.
  - Deassert req at the edge ending DONE, or keep it high to request again.
  - A held req is granted again from IDLE, subject to round-robin.
- Timing: latency from grant edge to ack = 3 cycles. Throughput = 1 transaction per 4 cycles.
- Contention: under continuous requests from both ports, grants strictly alternate. Neither port starves.
- Address and data outputs hold their last values in IDLE. No change without a grant.
- Write then read of the same address on consecutive transactions returns the new data: `DataMem` has completed the write before the read's SETUP.

Optional Feature:
- Macro: DM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, port 0 always wins simultaneous requests. lastGnt is still maintained but not used for selection.
- Undefined: round-robin as above.

Test Plan:
- Port 0 write, then port 0 read:
  - Write: req0=1, we0=1, addr0=1, wdata0=47 -> dmWrite high for exactly 1 cycle (the ACCESS cycle) with dmWrDat_addr=1, dmWrDat=47; ack0 pulses 3 cycles after grant.
  - Read: req0 read, addr0=1 -> rdata0=47 at ack0; rdata1 unchanged.
- Simultaneous requests after reset:
  - Stimulus: port 0 writes 74 to addr 2; port 1 reads addr 2.
  - Port 0 is granted first, then port 1; rdata1=74.
  - With DM_ARB_FIXED_PRIO_EN, a held req0 blocks port 1 indefinitely.
- Both ports hold req for 8 transactions:
  - Round-robin: acks alternate 0,1,0,1,...; spacing is 4 cycles.
  - With DM_ARB_FIXED_PRIO_EN: ack0 only.
- Inputs change after grant:
  - Change addr0 and wdata0 to 5/99 during SETUP of a write to addr 3, data 11 -> memory addr 3 holds 11; addr 5 untouched.
- Reset mid-transaction:
  - Assert rst_n=0 during ACCESS of a write -> dmWrite falls without waiting for clk; busy=0; no ack.
  - After release: state IDLE; a fresh read returns the expected contents.
- Idle hold:
  - No requests for 10 cycles after a transaction -> dm* outputs unchanged; dmWrite=0; busy=0; acks=0.
